// File: rtl/watchdog_reset.sv
// watchdog_reset: watchdog on the design side of the reset path.
//
// Counts down a programmable timeout. If nobody kicks it, the block first
// raises warn and then drives a fixed-length active-low reset request
// (bite_resetn). That request is meant for the board reset generator, which
// in turn drives resetn back into this block.
//
// Build option: define WDT_LOCK_EN to lock the watchdog once armed.
//   - enable=0 is ignored in RUN/WARN; only bite completion or resetn
//     return the block to IDLE.
//   - timeout is latched on arm, and kicks reload that latched value.
// Without the macro, disarm is allowed and timeout is resampled on every kick.
//
// Ports:
//   clk         in   design clock, all state on rising edge
//   resetn      in   asynchronous active-low reset
//   enable      in   arm watchdog (level)
//   kick        in   reload counter, sampled every cycle
//   timeout     in   reload value T (0 is treated as all-ones)
//   warn        out  registered, high in WARN state
//   bite_resetn out  registered active-low reset request
//   count       out  current counter value
//   state       out  IDLE=0, RUN=1, WARN=2, BITE=3
//
// Integration: route bite_resetn through the board reset generator, never
// directly to resetn. A direct loop would truncate the pulse after the
// reset path latency.
module watchdog_reset #(
  parameter int TIMEOUT_BITS = 16,
  parameter int WARN_CYCLES  = 256,
  parameter int BITE_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    kick,
  input  logic [TIMEOUT_BITS-1:0] timeout,
  output logic                    warn,
  output logic                    bite_resetn,
  output logic [TIMEOUT_BITS-1:0] count,
  output logic [1:0]              state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WARN = 2'd2;
  localparam logic [1:0] S_BITE = 2'd3;

  localparam logic [TIMEOUT_BITS-1:0] WARN_TH   = TIMEOUT_BITS'(WARN_CYCLES);
  localparam logic [TIMEOUT_BITS-1:0] BITE_LOAD = TIMEOUT_BITS'(BITE_CYCLES - 1);

  // A zero timeout would bite immediately; map it to the longest interval.
  logic [TIMEOUT_BITS-1:0] t_in;
  assign t_in = (timeout == '0) ? '1 : timeout;

  logic [TIMEOUT_BITS-1:0] reload;
  logic                    disarm;

`ifdef WDT_LOCK_EN
  // Timeout captured at arm time; later changes on the input are ignored.
  logic [TIMEOUT_BITS-1:0] t_lat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         t_lat <= '1;
    else if (state == S_IDLE && enable)  t_lat <= t_in;
  end

  assign reload = t_lat;
  assign disarm = 1'b0;
`else
  assign reload = t_in;
  assign disarm = ~enable;
`endif

  // Saturating decrement: the counter never wraps.
  logic [TIMEOUT_BITS-1:0] dec;
  assign dec = (count == '0) ? '0 : count - 1'b1;

  logic [1:0]              state_nxt;
  logic [TIMEOUT_BITS-1:0] count_nxt;
  logic                    warn_nxt;
  logic                    bite_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    warn_nxt  = warn;
    bite_nxt  = bite_resetn;
    case (state)
      S_IDLE: begin
        // Arm uses the live timeout; kick has no meaning here.
        if (enable) begin
          state_nxt = S_RUN;
          count_nxt = t_in;
        end
      end
      S_RUN: begin
        if (disarm) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end else if (kick) begin
          count_nxt = reload;
        end else if (count <= WARN_TH) begin
          state_nxt = S_WARN;
          warn_nxt  = 1'b1;
          count_nxt = dec;
        end else begin
          count_nxt = dec;
        end
      end
      S_WARN: begin
        // Kick beats expiry: a kick seen while count==0 still avoids a bite.
        if (disarm) begin
          state_nxt = S_IDLE;
          warn_nxt  = 1'b0;
          count_nxt = '0;
        end else if (kick) begin
          state_nxt = S_RUN;
          warn_nxt  = 1'b0;
          count_nxt = reload;
        end else if (count == '0) begin
          state_nxt = S_BITE;
          warn_nxt  = 1'b0;
          bite_nxt  = 1'b0;
          count_nxt = BITE_LOAD;
        end else begin
          count_nxt = dec;
        end
      end
      default: begin
        // BITE: the pulse is uninterruptible except by resetn. Loading
        // BITE_CYCLES-1 and leaving on count==0 gives exactly BITE_CYCLES low.
        if (count == '0) begin
          state_nxt = S_IDLE;
          bite_nxt  = 1'b1;
        end else begin
          count_nxt = dec;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      count       <= '0;
      warn        <= 1'b0;
      bite_resetn <= 1'b1;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      warn        <= warn_nxt;
      bite_resetn <= bite_nxt;
    end
  end

endmodule

// File: tb/tb_watchdog_reset.sv
// Directed bench for watchdog_reset (default build, WDT_LOCK_EN undefined).
// Edge numbering follows the arm convention: the edge where IDLE sees
// enable=1 is edge 0. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_watchdog_reset;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        kick;
  logic [15:0] timeout;
  logic        warn;
  logic        bite_resetn;
  logic [15:0] count;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  watchdog_reset #(
    .TIMEOUT_BITS(16),
    .WARN_CYCLES (10),
    .BITE_CYCLES (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .kick       (kick),
    .timeout    (timeout),
    .warn       (warn),
    .bite_resetn(bite_resetn),
    .count      (count),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drop to IDLE (from IDLE/RUN/WARN), then arm: returns just after edge 0.
  task automatic arm(input logic [15:0] t);
    enable = 1'b0;
    kick   = 1'b0;
    step();
    timeout = t;
    enable  = 1'b1;
    step();
  endtask

  initial begin
    int first_warn, bite_fall, bite_rise, low_cnt, min_cnt;
    bit saw_warn, saw_bite;

    resetn  = 1'b0;
    enable  = 1'b1;
    kick    = 1'b1;
    timeout = 16'd100;

    // Reset held for 3 cycles with enable/kick active.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_warn", warn, 0);
      chk("rst_bite", bite_resetn, 1);
    end
    enable = 1'b0;
    kick   = 1'b0;
    resetn = 1'b1;
    step();
    chk("idle_after_rst", state, 0);

    // Full timeout sequence, T=100, W=10, B=16.
    timeout = 16'd100;
    enable  = 1'b1;
    step();
    chk("arm_state", state, 1);
    chk("arm_count", count, 100);
    first_warn = -1; bite_fall = -1; bite_rise = -1; low_cnt = 0;
    for (int e = 1; e <= 118; e++) begin
      step();
      if (warn && first_warn < 0) first_warn = e;
      if (!bite_resetn && bite_fall < 0) bite_fall = e;
      if (bite_resetn && bite_fall >= 0 && bite_rise < 0) bite_rise = e;
      if (!bite_resetn) low_cnt++;
      if (e == 90)  chk("e90_count", count, 10);
      if (e == 101) chk("e101_count", count, 15);
      if (e == 117) chk("e117_state", state, 0);
      if (e == 118) begin
        chk("rearm_state", state, 1);
        chk("rearm_count", count, 100);
      end
    end
    chk("warn_rise_edge", first_warn, 91);
    chk("bite_fall_edge", bite_fall, 101);
    chk("bite_rise_edge", bite_rise, 117);
    chk("bite_low_cycles", low_cnt, 16);

    // Kick while in WARN at edge 95.
    arm(16'd100);
    repeat (94) step();
    chk("pre_kick_state", state, 2);
    chk("pre_kick_warn", warn, 1);
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("warn_kick_state", state, 1);
    chk("warn_kick_count", count, 100);
    chk("warn_kick_warn", warn, 0);
    saw_bite = 1'b0;
    repeat (60) begin
      step();
      if (!bite_resetn) saw_bite = 1'b1;
    end
    chk("warn_kick_nobite", saw_bite, 0);

    // Kick in the cycle WARN observes count==0.
    arm(16'd100);
    repeat (100) step();
    chk("zero_state", state, 2);
    chk("zero_count", count, 0);
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("zero_kick_state", state, 1);
    chk("zero_kick_count", count, 100);
    chk("zero_kick_bite", bite_resetn, 1);

    // Periodic kick every 50 cycles for 1000 cycles.
    arm(16'd100);
    saw_warn = 1'b0; saw_bite = 1'b0; min_cnt = 100;
    for (int c = 1; c <= 1000; c++) begin
      kick = (c % 50 == 0);
      step();
      if (warn) saw_warn = 1'b1;
      if (!bite_resetn) saw_bite = 1'b1;
      if (int'(count) < min_cnt) min_cnt = int'(count);
    end
    kick = 1'b0;
    chk("periodic_warn", saw_warn, 0);
    chk("periodic_bite", saw_bite, 0);
    chk("periodic_min", min_cnt, 51);

    // Disarm at edge 50 together with a kick: disarm wins.
    arm(16'd100);
    repeat (49) step();
    enable = 1'b0;
    kick   = 1'b1;
    step();
    chk("disarm_state", state, 0);
    chk("disarm_count", count, 0);
    step();
    chk("idle_kick_state", state, 0);
    chk("idle_kick_count", count, 0);
    kick = 1'b0;

    // Disarm from WARN.
    arm(16'd100);
    repeat (92) step();
    chk("dwarn_pre", state, 2);
    enable = 1'b0;
    step();
    chk("dwarn_state", state, 0);
    chk("dwarn_warn", warn, 0);
    chk("dwarn_count", count, 0);

    // Kick resamples a changed timeout.
    arm(16'd100);
    repeat (3) step();
    timeout = 16'd200;
    kick    = 1'b1;
    step();
    kick = 1'b0;
    chk("resample_count", count, 200);
    chk("resample_state", state, 1);

    // T=0 maps to all-ones on arm and on kick.
    arm(16'd0);
    chk("t0_arm_count", count, 65535);
    chk("t0_arm_state", state, 1);
    step();
    chk("t0_dec", count, 65534);
    kick = 1'b1;
    step();
    kick = 1'b0;
    chk("t0_kick_count", count, 65535);

    // T=5 < W: warn at edge 1, bite at edge 6.
    arm(16'd5);
    chk("t5_e0_count", count, 5);
    step();
    chk("t5_e1_state", state, 2);
    chk("t5_e1_warn", warn, 1);
    chk("t5_e1_count", count, 4);
    repeat (4) step();
    chk("t5_e5_count", count, 0);
    chk("t5_e5_bite", bite_resetn, 1);
    step();
    chk("t5_e6_state", state, 3);
    chk("t5_e6_bite", bite_resetn, 0);
    chk("t5_e6_warn", warn, 0);
    chk("t5_e6_count", count, 15);
    // enable/kick ignored during BITE.
    enable = 1'b0;
    kick   = 1'b1;
    step();
    chk("bite_ign_state", state, 3);
    chk("bite_ign_count", count, 14);
    chk("bite_ign_bite", bite_resetn, 0);
    // Asynchronous reset mid-bite truncates the pulse.
    #2;
    resetn = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_bite", bite_resetn, 1);
    chk("async_count", count, 0);
    step();
    resetn = 1'b1;
    kick   = 1'b0;
    step();
    chk("post_async_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/watchdog_reset.md
Name: watchdog_reset

Overview:
- Watchdog on the design side of the reset path.
- Consumes the design clock `clk` and reset `resetn`. Counts down a programmable timeout.
- If software/logic fails to kick it: raises an early warning, then emits a fixed-length active-low reset request (`bite_resetn`). That request is fed back into the board-level reset input of the clock/reset generator.
- Closes the loop: the generator issues reset, this block requests it.

Parameters:
- TIMEOUT_BITS, 16: width of countdown counter and of `timeout` input.
- WARN_CYCLES, 256: remaining-count threshold at which `warn` asserts. Must be < 2^TIMEOUT_BITS.
- BITE_CYCLES, 16: exact length in cycles of the `bite_resetn` low pulse. Range 1..2^TIMEOUT_BITS-1.

Ports:
- clk  in  1  design clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  arm watchdog (level).
- kick  in  1  reload counter (single-cycle or level; sampled every cycle).
- timeout  in  TIMEOUT_BITS  reload value T, sampled on arm and on every accepted kick. 0 treated as all-ones.
- warn  out  1  registered; high in WARN state.
- bite_resetn  out  1  registered, active-low reset request.
- count  out  TIMEOUT_BITS  current counter value.
- state  out  2  IDLE=0, RUN=1, WARN=2, BITE=3.

Behaviour:
- Async reset (resetn low): state=IDLE, count=0, warn=0, bite_resetn=1, immediately and held while low.
- IDLE:
  - enable=1: go to RUN, count<=T.
  - kick ignored.
- RUN, evaluated in this priority order:
  1. enable=0: go to IDLE, count<=0.
  2. kick=1: count<=T, stay RUN.
  3. count<=WARN_CYCLES: go to WARN, warn<=1, count<=count-1 (saturate at 0).
  4. Otherwise: count<=count-1.
- WARN, evaluated in this priority order:
  1. enable=0: go to IDLE, warn<=0, count<=0.
  2. kick=1: go to RUN, count<=T, warn<=0.
  3. count==0: go to BITE, warn<=0, bite_resetn<=0, count<=BITE_CYCLES-1.
  4. Otherwise: count<=count-1.
- BITE:
  - enable and kick ignored.
  - count==0: go to IDLE, bite_resetn<=1.
  - Otherwise: count<=count-1.
  - bite_resetn stays low for exactly BITE_CYCLES cycles.
- Timing, with no kicks and arm at edge 0 (IDLE sees enable=1):
  - warn rises at edge max(1, T-WARN_CYCLES+1).
  - bite_resetn falls at edge T+1.
  - bite_resetn rises at edge T+1+BITE_CYCLES.
- Simultaneous events:
  - kick and count reaching 0 in the same cycle: kick wins, no bite.
  - enable=0 with kick in the same cycle: enable=0 wins.
- T<=WARN_CYCLES: WARN entered on the first RUN cycle. This is legal.
- Arithmetic: count never wraps. Decrement saturates at 0.
- resetn asserted mid-BITE: pulse truncated, block returns to IDLE.
- If bite_resetn is wired back to resetn, this truncation ends the pulse after the reset path latency. Integration must route bite_resetn through the board reset generator, never directly to this block's resetn.
- Back-to-back operation: if enable is still high after BITE→IDLE, the block re-arms on the next edge.

Optional Feature:
- Macro: WDT_LOCK_EN.
- Defined:
  - Once in RUN or WARN, enable=0 is ignored. Only BITE completion or resetn returns to IDLE.
  - timeout is sampled only on arm; kicks reload the value latched at arm.
- Undefined: behaviour exactly as above (disarm allowed, timeout sampled on every kick).

Test Plan:
- Reset values: hold resetn low 3 cycles with enable=1, kick=1 → state=0, count=0, warn=0, bite_resetn=1 throughout.
- Timeout sequence: T=100, W=10, B=16, enable=1 from edge 0, no kicks → warn rises edge 91, bite_resetn falls edge 101, low exactly 16 cycles, state returns to 0 at edge 117, re-arms at edge 118.
- Periodic kick: T=100, kick every 50 cycles for 1000 cycles → warn=0 and bite_resetn=1 throughout; count never below 50.
- Kick in WARN: T=100, W=10, kick at edge 95 → state RUN, count=100, warn=0 next edge, no bite.
- Boundary conditions:
  - T=0 → reload 65535.
  - T=5, W=10 → warn at edge 1, bite at edge 6.
  - kick at the cycle count==0 is observed in WARN → no bite.
- Disarm, WDT_LOCK_EN undefined: enable=0 at edge 50 → IDLE, count=0. Same stimulus with WDT_LOCK_EN defined → bite still at edge 101.
